// File: rtl/dcache_sa_top.sv
// Set-associative, write-back, write-allocate data cache with per-set LRU replacement.
// Hits complete in the request cycle. A miss stalls the CPU through write-back, refill and one settle cycle.
module dcache_sa_top #(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [31:0]          p1_data_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o
);
  localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int IW  = $clog2(SETS);
  localparam int OW  = $clog2(LINE_BITS / 8);
  localparam int TW  = ADDR_W - IW - OW;
  localparam int WPL = LINE_BITS / 32;
  localparam int WW  = OW - 2;

  typedef logic [WPL-1:0][31:0]     line_t;
  typedef logic [WAYS-1:0][AW-1:0]  ages_t;
  typedef enum logic [2:0] {S_IDLE, S_MISS, S_WB, S_RD, S_FILL} state_t;

  // Touched way becomes youngest; only ways younger than it age, so ages stay a permutation.
  function automatic ages_t lru_touch(input ages_t a, input logic [AW-1:0] t);
    ages_t r;
    for (int w = 0; w < WAYS; w++) begin
      if (w == int'(t))      r[w] = '0;
      else if (a[w] < a[t])  r[w] = a[w] + 1'b1;
      else                   r[w] = a[w];
    end
    return r;
  endfunction

  function automatic ages_t ages_init();
    ages_t r;
    for (int w = 0; w < WAYS; w++) r[w] = AW'(w);
    return r;
  endfunction

  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [TW-1:0]             tag_q  [SETS][WAYS];
  line_t                     data_q [SETS][WAYS];
  ages_t                     age_q  [SETS];

  state_t                    state_q, state_d;
  logic [AW-1:0]             vway_q, vway_d;
  logic [TW-1:0]             ltag_q, ltag_d;
  logic [IW-1:0]             lidx_q, lidx_d;
  logic                      men_q, men_d;
  logic                      mwr_q, mwr_d;
  logic [ADDR_W-1:0]         maddr_q, maddr_d;
  logic [LINE_BITS-1:0]      mdata_q, mdata_d;

  logic [TW-1:0]             req_tag;
  logic [IW-1:0]             req_idx;
  logic [WW-1:0]             req_word;
  logic                      req;
  logic [WAYS-1:0]           match_way, hit_way;
  logic                      hit;
  logic [AW-1:0]             hit_idx;
  line_t                     hit_line;
  logic [AW-1:0]             vic_way;
  logic                      vic_found;
  logic                      fill_en, store_en;
  logic                      addr_lo_unused;

  assign req_tag        = p1_addr_i[ADDR_W-1 -: TW];
  assign req_idx        = p1_addr_i[OW +: IW];
  assign req_word       = p1_addr_i[2 +: WW];
  assign req            = p1_MemRead_i | p1_MemWrite_i;
  assign addr_lo_unused = ^p1_addr_i[1:0];

  // Lookup is only trusted in IDLE; during a refill the arrays are still in motion.
  always_comb begin
    match_way = '0;
    for (int w = 0; w < WAYS; w++)
      match_way[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
    hit_way = (req && state_q == S_IDLE) ? match_way : '0;
  end

  always_comb begin
    hit_idx = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_way[w]) hit_idx = hit_idx | AW'(w);
  end

  assign hit        = |hit_way;
  assign hit_line   = data_q[req_idx][hit_idx];
  assign p1_data_o  = (hit && p1_MemRead_i) ? hit_line[req_word] : 32'd0;
  assign p1_stall_o = req & ~hit;
  assign store_en   = hit & p1_MemWrite_i;
  assign fill_en    = (state_q == S_RD) && mem_ack_i;

  // Prefer the lowest invalid way; otherwise the oldest way of the set.
  always_comb begin
    vic_way   = '0;
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[req_idx][w]) begin
        vic_way   = AW'(w);
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++)
        if (age_q[req_idx][w] == AW'(WAYS - 1)) vic_way = AW'(w);
    end
  end

  always_comb begin
    state_d = state_q;
    vway_d  = vway_q;
    ltag_d  = ltag_q;
    lidx_d  = lidx_q;
    men_d   = men_q;
    mwr_d   = mwr_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    case (state_q)
      S_IDLE: if (req && !hit) state_d = S_MISS;
      S_MISS: begin
        vway_d  = vic_way;
        ltag_d  = req_tag;
        lidx_d  = req_idx;
        mdata_d = data_q[req_idx][vic_way];
        men_d   = 1'b1;
        if (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way]) begin
          mwr_d   = 1'b1;
          maddr_d = {tag_q[req_idx][vic_way], req_idx, {OW{1'b0}}};
          state_d = S_WB;
        end else begin
          mwr_d   = 1'b0;
          maddr_d = {req_tag, req_idx, {OW{1'b0}}};
          state_d = S_RD;
        end
      end
      S_WB: if (mem_ack_i) begin
        mwr_d   = 1'b0;
        maddr_d = {ltag_q, lidx_q, {OW{1'b0}}};
        state_d = S_RD;
      end
      S_RD: if (mem_ack_i) begin
        men_d   = 1'b0;
        state_d = S_FILL;
      end
      S_FILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      men_q   <= 1'b0;
      mwr_q   <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      men_q   <= men_d;
      mwr_q   <= mwr_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    vway_q <= vway_d;
    ltag_q <= ltag_d;
    lidx_q <= lidx_d;
  end

  // Line state and replacement ages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++) age_q[s] <= ages_init();
    end else if (fill_en) begin
      valid_q[lidx_q][vway_q] <= 1'b1;
      dirty_q[lidx_q][vway_q] <= 1'b0;
      age_q[lidx_q]           <= lru_touch(age_q[lidx_q], vway_q);
    end else if (hit) begin
      age_q[req_idx] <= lru_touch(age_q[req_idx], hit_idx);
      if (p1_MemWrite_i) dirty_q[req_idx][hit_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[lidx_q][vway_q]  <= ltag_q;
      data_q[lidx_q][vway_q] <= line_t'(mem_data_i);
    end else if (store_en) begin
      data_q[req_idx][hit_idx][req_word] <= p1_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && req) assert ($onehot0(match_way));
  end

  assign mem_enable_o = men_q;
  assign mem_write_o  = mwr_q;
  assign mem_addr_o   = maddr_q;
  assign mem_data_o   = mdata_q;
endmodule
